// File: rtl/ss_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ss_pkg
// Desc     : Shared types, constants and the hex font for the seven-segment
//            multiplexed display driver.
// Revision : 1.0 - initial release
// ============================================================================
package ss_pkg;

    // Segment vector ordered {g,f,e,d,c,b,a}
    typedef logic [6:0] seg_t;

    // All segments dark on an active-low display
    localparam seg_t SEG_BLANK      = 7'h7F;

    // Board segment pins sink current: a 0 lights the segment
    localparam bit   SEG_ACTIVE_LOW = 1'b1;

    // Hex digit to active-low gfedcba pattern (upper-case A/C/E/F,
    // lower-case b/d so that every glyph is distinct)
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ss_hex_font.sv
`default_nettype none
// ============================================================================
// Module   : ss_hex_font
// Desc     : Combinational hex-nibble to seven-segment decoder. Output polarity
//            follows the board's segment drive polarity.
// Revision : 1.0 - initial release
// ============================================================================
module ss_hex_font
    import ss_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    seg_t w_raw_seg;

    // Font table is stored active-low; invert only for an active-high board
    assign w_raw_seg = hex_to_seg(i_nibble);
    assign o_seg     = SEG_ACTIVE_LOW ? w_raw_seg : ~w_raw_seg;

endmodule
`default_nettype wire

// File: rtl/ss_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : ss_mux_driver
// Desc     : Time-multiplexed driver for an N-digit common-anode seven-segment
//            display. Double-buffered value/dp/blanking applied at frame
//            boundaries, leading-zero blanking, PWM brightness, one dead-time
//            clock at the start of every digit slot, registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ss_mux_driver
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int PWM_BITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic                    enable,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_sync
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] c_last_div = DIV_W'(REFRESH_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]      r_div_cnt;
    logic [IDX_W-1:0]      r_dig_idx;
    logic [PWM_BITS-1:0]   r_pwm_cnt;

    logic [VAL_W-1:0]      r_shd_value;
    logic [NUM_DIGITS-1:0] r_shd_dp;
    logic                  r_shd_blz;
    logic                  r_pending;

    logic [VAL_W-1:0]      r_act_value;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic                  r_act_blz;

    logic [6:0]            r_seg_n;
    logic                  r_dp_n;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic                  r_frame_sync;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                  w_slot_end;
    logic                  w_wrap;
    logic [3:0]            w_nibbles [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic [3:0]            w_sel_nib;
    seg_t                  w_font_seg;
    logic                  w_blank;
    logic                  w_pwm_on;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an_sel;

    assign w_slot_end = (r_div_cnt == c_last_div);
    // Frame boundary: last slot of the last digit finishing while running
    assign w_wrap     = enable && w_slot_end && (r_dig_idx == c_last_idx);

    // Split the active value into nibbles and flag, per digit, whether it and
    // every more-significant nibble are zero (candidate for blanking)
    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_nibbles[i]    = r_act_value[4*i +: 4];
            assign w_upper_zero[i] = (r_act_value[VAL_W-1:4*i] == '0);
        end
    endgenerate

    assign w_sel_nib = w_nibbles[r_dig_idx];

    ss_hex_font u_font (
        .i_nibble (w_sel_nib),
        .o_seg    (w_font_seg)
    );

    // Digit 0 always shows something so a zero value never goes fully dark
    assign w_blank  = r_act_blz && (r_dig_idx != '0) && w_upper_zero[r_dig_idx];

    // Full-scale brightness bypasses the compare so the anode never drops out
    assign w_pwm_on = (brightness == '1) || (r_pwm_cnt < brightness);

    // First clock of each slot is dead time so segments settle before the
    // new anode turns on
    assign w_lit    = enable && (r_div_cnt != '0) && w_pwm_on;
    assign w_an_sel = ~(NUM_DIGITS'(1) << r_dig_idx);

    // ------------------------------------------------------------------
    // Slot divider and digit index; parked at slot 0 / digit 0 when disabled
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else if (!enable) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_dig_idx <= (r_dig_idx == c_last_idx) ? '0 : r_dig_idx + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Free-running PWM phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Shadow/active double buffer; a load coinciding with the wrap goes
    // straight to the active copy so it is not delayed a whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd_value <= '0;
            r_shd_dp    <= '0;
            r_shd_blz   <= 1'b0;
            r_pending   <= 1'b0;
            r_act_value <= '0;
            r_act_dp    <= '0;
            r_act_blz   <= 1'b0;
        end else if (load && w_wrap) begin
            r_act_value <= value;
            r_act_dp    <= dp_in;
            r_act_blz   <= blank_lz;
            r_pending   <= 1'b0;
        end else if (load) begin
            r_shd_value <= value;
            r_shd_dp    <= dp_in;
            r_shd_blz   <= blank_lz;
            r_pending   <= 1'b1;
        end else if (w_wrap && r_pending) begin
            r_act_value <= r_shd_value;
            r_act_dp    <= r_shd_dp;
            r_act_blz   <= r_shd_blz;
            r_pending   <= 1'b0;
        end
    end

    // Registered pin drivers: everything dark while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_an_n       <= '1;
            r_frame_sync <= 1'b0;
        end else begin
            r_frame_sync <= w_wrap;
            r_an_n       <= w_lit ? w_an_sel : '1;
            if (!enable) begin
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
            end else begin
                r_seg_n <= w_blank ? SEG_BLANK : w_font_seg;
                r_dp_n  <= ~r_act_dp[r_dig_idx];
            end
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_sync = r_frame_sync;

endmodule
`default_nettype wire

// File: doc/ss_mux_driver.md
Name: ss_mux_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Shows a packed hex value with per-digit decimal points, optional leading-zero blanking and PWM brightness.
- New values are double-buffered and applied only at frame boundaries, so the display never tears.
- Sits between the datapath, which presents values, and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits / anode lines (1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= 4).
- PWM_BITS, 4, width of the brightness control and the PWM counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  packed hex nibbles; nibble i drives digit i, digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  single-cycle strobe that captures value, dp_in and blank_lz into the shadow registers.
- blank_lz  in  1  leading-zero suppression enable.
- enable  in  1  display enable.
- brightness  in  PWM_BITS  on-time level.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  NUM_DIGITS  anode selects, active-low, one-hot-or-none.
- frame_sync  out  1  one-cycle pulse when digit index wraps to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Outputs: seg_n=7'h7F, dp_n=1, an_n all 1s, frame_sync=0.
  - Internal state: all counters=0, digit index=0, active and shadow registers=0, pending=0.
- Slot counter: div_cnt counts 0..REFRESH_DIV-1. At the terminal count it returns to 0 and dig_idx advances. dig_idx wraps from NUM_DIGITS-1 to 0; on that wrap, frame_sync pulses.
- Buffering:
  - load=1 writes the shadow registers and sets pending.
  - At the frame wrap, if pending, shadow is copied to active and pending clears.
  - A load on the same cycle as the wrap bypasses the shadow: it goes straight to active and leaves pending=0.
  - A second load before the wrap overwrites the shadow; last write wins.
- Font (hex 0-F, active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking: when active blank_lz=1, digit i (i>0) is blanked if nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked. A blanked digit drives seg_n=7'h7F but keeps its dp.
- PWM: pwm_cnt is a free-running PWM_BITS counter. The anode is lit when pwm_cnt < brightness. If brightness is all 1s, the anode is lit continuously. brightness=0 gives a dark display.
- Dead time: an_n is all 1s during the first clock of every slot (div_cnt==0) for anti-ghosting. seg_n and dp_n change on that cycle.
- Latency: all outputs are registered, so an_n, seg_n and dp_n reflect the state of the previous cycle (1 cycle).
- enable=0:
  - an_n all 1s, seg_n=7'h7F, dp_n=1.
  - div_cnt and dig_idx held at 0; frame_sync=0.
  - Loads are still captured and applied at the first wrap after enable returns. The first slot after re-enable starts at digit 0.
- Reset mid-frame: all state returns to reset values immediately; shadow contents are lost.

Decomposition:
- Package ss_pkg holds:
  - typedef seg_t (logic [6:0]);
  - constants SEG_BLANK=7'h7F and SEG_ACTIVE_LOW=1;
  - function hex_to_seg(nibble) returning seg_t (font above).
- Sub-module ss_hex_font: combinational wrapper around hex_to_seg, one instance on the selected nibble.
- Counters, buffering, blanking and PWM stay in ss_mux_driver.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, PWM_BITS=2, brightness=3 unless stated):
- Reset release, enable=1, no load -> an_n cycles 1110,1101,1011,0111 with 8-cycle slots. seg_n=1000000 except 1111 on each slot's first cycle. frame_sync pulses every 32 cycles.
- load value=16'h12AF, dp_in=4'b0100 mid-frame -> old digits persist until frame_sync. Next frame shows digit0=0001110, digit1=0001000, digit2=0100100 with dp_n=0, digit3=1111001.
- blank_lz=1, value=16'h0050 -> digits 3 and 2 show 7'h7F with anode slots still timed; digit1=0010010, digit0=1000000. value=16'h0000 shows digit0 only.
- brightness=1 -> anode lit 1 of every 4 cycles. brightness=0 -> an_n all 1s. brightness=3 -> lit on every cycle except dead-time cycles.
- load asserted exactly on the wrap cycle with 16'hBEEF -> following frame shows b,E,E,F, pending=0. Two loads in one frame -> only the second is displayed.
- rst_n asserted asynchronously mid-slot -> outputs go to reset values within the same cycle without a clock. enable=0 for 20 cycles then 1 -> restart at digit 0, div_cnt=0.
